// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the scanned 7-segment driver.
//   - SEG_A..SEG_G : bit positions of each segment inside a 7-bit pattern
//   - HEX_SEG      : 16-entry nibble -> segment table, lit-high (1 = segment on)
//   - apply_polarity() : converts a lit-high pattern to pin polarity
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    function automatic seg_t seg_bit(input int unsigned s);
        return seg_t'(1) << s;
    endfunction

    // Each glyph is written as "all on except these", matching how the
    // character set is usually described.
    localparam seg_t HEX_SEG [16] = '{
        ~seg_bit(SEG_G),                                                           // 0
        ~(seg_bit(SEG_A) | seg_bit(SEG_D) | seg_bit(SEG_E) | seg_bit(SEG_F) | seg_bit(SEG_G)), // 1
        ~(seg_bit(SEG_C) | seg_bit(SEG_F)),                                        // 2
        ~(seg_bit(SEG_E) | seg_bit(SEG_F)),                                        // 3
        ~(seg_bit(SEG_A) | seg_bit(SEG_D) | seg_bit(SEG_E)),                       // 4
        ~(seg_bit(SEG_B) | seg_bit(SEG_E)),                                        // 5
        ~seg_bit(SEG_B),                                                           // 6
        ~(seg_bit(SEG_D) | seg_bit(SEG_E) | seg_bit(SEG_F) | seg_bit(SEG_G)),      // 7
        7'h7F,                                                                     // 8
        ~seg_bit(SEG_E),                                                           // 9
        ~seg_bit(SEG_D),                                                           // A
        ~(seg_bit(SEG_A) | seg_bit(SEG_B)),                                        // b
        ~(seg_bit(SEG_B) | seg_bit(SEG_C) | seg_bit(SEG_G)),                       // C
        ~(seg_bit(SEG_A) | seg_bit(SEG_F)),                                        // d
        ~(seg_bit(SEG_B) | seg_bit(SEG_C)),                                        // E
        ~(seg_bit(SEG_B) | seg_bit(SEG_C) | seg_bit(SEG_D))                        // F
    };

    // Up to 8 bits so the same helper serves segments and anodes.
    function automatic logic [7:0] apply_polarity(input logic [7:0] lit,
                                                  input logic       active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: register-side load bus of the scanned display driver.
//   load   : single-cycle capture strobe
//   value  : 4*DIGITS hex nibbles, nibble 0 = rightmost digit
//   dp_in  : per-digit decimal point (1 = lit)
//   blank  : per-digit force-dark (1 = dark)
//   lzb_en : leading-zero blanking enable
// master drives the bus, slave (the display driver) samples it.
interface seg7_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank;
    logic                  lzb_en;

    modport master (output load, value, dp_in, blank, lzb_en);
    modport slave  (input  load, value, dp_in, blank, lzb_en);
endinterface

// File: rtl/seg7_hex_lut.sv
// seg7_hex_lut: combinational nibble -> lit-high 7-segment pattern.
//   nibble : hex digit in
//   lit    : segment pattern, bit SEG_A..SEG_G, 1 = segment on
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       lit
);
    assign lit = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed driver for a DIGITS-wide common-anode display.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load bus (seg7_scan_mux_if.slave)
//   seg        : shared segment lines, seg[0]=a .. seg[6]=g
//   dp         : shared decimal-point line
//   an         : one anode enable per digit
//   frame_done : one-cycle pulse on the last cycle of each full scan
// A new load is held in a pending buffer and only moved to the displayed
// buffer at frame end, so a frame never mixes old and new content.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_mux_if.slave       bus,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic [DIGITS-1:0]    an,
    output logic                 frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    // ---------------- scan counters ----------------
    logic [PW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          slot_end;
    logic          idx_last;
    logic          frame_end;

    assign slot_end  = (cnt == PW'(PRESCALE - 1));
    assign idx_last  = (idx == IW'(DIGITS - 1));
    assign frame_end = slot_end && idx_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx_last ? '0 : idx + 1'b1;
        end
    end

    // ---------------- content buffers ----------------
    logic [VW-1:0]     act_value,  pend_value;
    logic [DIGITS-1:0] act_dp,     pend_dp;
    logic [DIGITS-1:0] act_blank,  pend_blank;
    logic              act_lzb,    pend_lzb;
    logic              pend_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value  <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            act_lzb    <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_lzb   <= 1'b0;
            pend_valid <= 1'b0;
        end else if (frame_end && bus.load) begin
            // Load on the frame boundary goes straight to the display.
            act_value  <= bus.value;
            act_dp     <= bus.dp_in;
            act_blank  <= bus.blank;
            act_lzb    <= bus.lzb_en;
            pend_valid <= 1'b0;
        end else if (frame_end && pend_valid) begin
            act_value  <= pend_value;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            act_lzb    <= pend_lzb;
            pend_valid <= 1'b0;
        end else if (bus.load) begin
            pend_value <= bus.value;
            pend_dp    <= bus.dp_in;
            pend_blank <= bus.blank;
            pend_lzb   <= bus.lzb_en;
            pend_valid <= 1'b1;
        end
    end

    // ---------------- per-digit darkness ----------------
    logic [DIGITS-1:0] zero_run;   // nibble i and all nibbles above it are 0
    logic [DIGITS-1:0] dark;

    always_comb begin
        zero_run = '0;
        dark     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            zero_run[i] = ((act_value >> (4 * i)) == '0);
            dark[i]     = act_blank[i] || (act_lzb && zero_run[i] && (i != 0));
        end
    end

    // ---------------- current-digit mux ----------------
    logic [3:0] cur_nib;
    logic       cur_dark;
    logic       cur_dp;
    seg_t       cur_lit;

    always_comb begin
        cur_nib  = '0;
        cur_dark = 1'b0;
        cur_dp   = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib  = act_value[4*k +: 4];
                cur_dark = dark[k];
                cur_dp   = act_dp[k] && !act_blank[k];
            end
        end
    end

    seg7_hex_lut u_lut (
        .nibble (cur_nib),
        .lit    (cur_lit)
    );

    logic in_blank;
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (cnt < PW'(BLANK_CYCLES));
    end

    // ---------------- registered outputs (lit-high) ----------------
    seg_t              seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] an_q;
    logic              fd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            an_q  <= '0;
            fd_q  <= 1'b0;
        end else begin
            seg_q <= cur_dark ? '0 : cur_lit;
            dp_q  <= cur_dp;
            an_q  <= in_blank ? '0 : (DIGITS'(1) << idx);
            // Decoded one cycle early so the registered pulse coincides
            // with the wrap cycle itself, letting a load on it hit the bypass.
            fd_q  <= (cnt == PW'(PRESCALE - 2)) && idx_last;
        end
    end

    assign seg        = 7'(apply_polarity(8'(seg_q), SEG_ACTIVE_LOW));
    assign dp         = 1'(apply_polarity(8'(dp_q), SEG_ACTIVE_LOW));
    assign an         = DIGITS'(apply_polarity(8'(an_q), AN_ACTIVE_LOW));
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed + random stimulus against a cycle-count based
// reference model for a 4-digit active-low instance and a 1-digit
// active-high instance.
module tb_seg7_scan_mux;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int B  = 1;
    localparam int P1 = 3;
    localparam int B1 = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_mux_if #(.DIGITS(D)) bus0 ();
    seg7_scan_mux_if #(.DIGITS(1)) bus1 ();

    logic [6:0] seg0, seg1;
    logic       dp0, dp1, fd0, fd1;
    logic [3:0] an0;
    logic       an1;

    seg7_scan_mux #(
        .DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0)
    );

    seg7_scan_mux #(
        .DIGITS(1), .PRESCALE(P1), .BLANK_CYCLES(B1),
        .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  dpm;
        logic [3:0]  bl;
        logic        lz;
    } content_t;

    content_t act0, pend0, act1, pend1;
    bit       pv0, pv1;
    int       t;
    bit       seen_one;

    // Lit-high glyphs, bit0=a .. bit6=g.
    function automatic logic [6:0] hex_lit(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg_lit(input content_t c, input int i);
        bit is_dark;
        is_dark = c.bl[i] || (c.lz && (i != 0) && ((c.v >> (4 * i)) == 16'h0));
        return is_dark ? 7'h00 : hex_lit(c.v[4*i +: 4]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic buf_step(input bit fe, input bit ld, input content_t in,
                            inout content_t act, inout content_t pend, inout bit pv);
        if (fe && ld) begin
            act = in; pv = 1'b0;
        end else if (fe && pv) begin
            act = pend; pv = 1'b0;
        end else if (ld) begin
            pend = in; pv = 1'b1;
        end
    endtask

    task automatic reset_model();
        act0 = '0; pend0 = '0; act1 = '0; pend1 = '0;
        pv0 = 1'b0; pv1 = 1'b0; t = 0;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_an0"},  32'(an0),  32'hF);
        check({tag, "_seg0"}, 32'(seg0), 32'h7F);
        check({tag, "_dp0"},  32'(dp0),  32'h1);
        check({tag, "_fd0"},  32'(fd0),  32'h0);
        check({tag, "_an1"},  32'(an1),  32'h0);
        check({tag, "_seg1"}, 32'(seg1), 32'h00);
        check({tag, "_dp1"},  32'(dp1),  32'h0);
    endtask

    // One clock: predict pins from the model state before the edge, apply
    // buffer rules for the inputs present at the edge, compare at negedge.
    task automatic tick();
        int pos, idx, pos1;
        bit fe0, fe1, ld0, ld1;
        content_t in0, in1;
        logic [3:0] e_an; logic [6:0] e_seg; logic e_dp, e_fd;
        logic e_an1; logic [6:0] e_seg1; logic e_dp1, e_fd1;

        pos  = t % P;
        idx  = (t / P) % D;
        e_an = (pos < B) ? 4'hF : ~4'(1 << idx);
        e_seg = ~exp_seg_lit(act0, idx);
        e_dp  = ~(act0.dpm[idx] & ~act0.bl[idx]);
        fe0   = (pos == P - 1) && (idx == D - 1);

        pos1   = t % P1;
        e_an1  = (pos1 >= B1);
        e_seg1 = exp_seg_lit(act1, 0);
        e_dp1  = act1.dpm[0] & ~act1.bl[0];
        fe1    = (pos1 == P1 - 1);

        in0 = '{v: bus0.value, dpm: bus0.dp_in, bl: bus0.blank, lz: bus0.lzb_en};
        ld0 = bus0.load;
        in1 = '{v: {12'h0, bus1.value}, dpm: {3'b0, bus1.dp_in}, bl: {3'b0, bus1.blank},
                lz: bus1.lzb_en};
        ld1 = bus1.load;

        @(posedge clk);
        buf_step(fe0, ld0, in0, act0, pend0, pv0);
        buf_step(fe1, ld1, in1, act1, pend1, pv1);
        t++;
        e_fd  = ((t % P) == P - 1) && (((t / P) % D) == D - 1);
        e_fd1 = ((t % P1) == P1 - 1);

        @(negedge clk);
        check("an0",  32'(an0),  32'(e_an));
        check("seg0", 32'(seg0), 32'(e_seg));
        check("dp0",  32'(dp0),  32'(e_dp));
        check("fd0",  32'(fd0),  32'(e_fd));
        check("an1",  32'(an1),  32'(e_an1));
        check("seg1", 32'(seg1), 32'(e_seg1));
        check("dp1",  32'(dp1),  32'(e_dp1));
        check("fd1",  32'(fd1),  32'(e_fd1));
        if (an0 != 4'hF && seg0 == 7'h79) seen_one = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load0(input logic [15:0] v, input logic [3:0] dpm,
                         input logic [3:0] bl, input logic lz);
        bus0.value = v; bus0.dp_in = dpm; bus0.blank = bl; bus0.lzb_en = lz;
        bus0.load = 1'b1;
        tick();
        bus0.load = 1'b0;
    endtask

    task automatic load1(input logic [3:0] v);
        bus1.value = v; bus1.dp_in = 1'b0; bus1.blank = 1'b0; bus1.lzb_en = 1'b0;
        bus1.load = 1'b1;
        tick();
        bus1.load = 1'b0;
    endtask

    initial begin
        bit found;
        logic [15:0] rv;

        rst_n = 1'b0;
        bus0.load = 1'b0; bus0.value = '0; bus0.dp_in = '0; bus0.blank = '0; bus0.lzb_en = 1'b0;
        bus1.load = 1'b0; bus1.value = '0; bus1.dp_in = '0; bus1.blank = '0; bus1.lzb_en = 1'b0;
        reset_model();
        #1;
        check_reset_pins("por");
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Basic scan and the 1-digit active-high instance showing 8.
        bus1.value = 4'h8; bus1.load = 1'b1;
        load0(16'h12AF, 4'h0, 4'h0, 1'b0);
        bus1.load = 1'b0;
        ticks(48);

        // Leading-zero blanking.
        load0(16'h0040, 4'h0, 4'h0, 1'b1);
        ticks(40);
        load0(16'h0000, 4'h0, 4'h0, 1'b1);
        ticks(40);

        // Tear-free update: two loads inside one frame, last one wins.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((t % (P * D)) == 5) found = 1'b1;
            else tick();
        end
        check("midframe_wait", 32'(found), 32'h1);
        seen_one = 1'b0;
        load0(16'h1111, 4'h0, 4'h0, 1'b0);
        ticks(3);
        load0(16'h2222, 4'h0, 4'h0, 1'b0);
        ticks(40);
        check("never_one", 32'(seen_one), 32'h0);

        // Load exactly on the frame_done cycle takes the bypass path.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (fd0 === 1'b1) found = 1'b1;
            else tick();
        end
        check("fd_wait", 32'(found), 32'h1);
        load0(16'h3333, 4'h0, 4'h0, 1'b0);
        ticks(20);

        // Blank suppresses dp; LZ-blank does not.
        load0(16'h5A3C, 4'b0101, 4'b0100, 1'b0);
        ticks(40);
        load0(16'h0007, 4'b1010, 4'b0000, 1'b1);
        ticks(40);

        // Asynchronous reset during digit 2.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (((t / P) % D) == 2 && (t % P) == 1) found = 1'b1;
            else tick();
        end
        check("digit2_wait", 32'(found), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_pins("async");
        check("async_fd1", 32'(fd1), 32'h0);
        @(negedge clk);
        check_reset_pins("held");
        rst_n = 1'b1;
        reset_model();
        ticks(20);
        load1(4'h8);
        ticks(12);

        // Random loads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rv = 16'($urandom);
                if ($urandom_range(0, 1) == 1) rv = rv & (16'hFFFF >> (4 * $urandom_range(1, 4)));
                bus0.value  = rv;
                bus0.dp_in  = 4'($urandom);
                bus0.blank  = 4'($urandom & $urandom);
                bus0.lzb_en = 1'($urandom);
                bus0.load   = 1'b1;
            end
            if ($urandom_range(0, 15) == 0) begin
                bus1.value  = 4'($urandom);
                bus1.dp_in  = 1'($urandom);
                bus1.blank  = ($urandom_range(0, 3) == 0);
                bus1.lzb_en = 1'($urandom);
                bus1.load   = 1'b1;
            end
            tick();
            bus0.load = 1'b0;
            bus1.load = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
